// File: rtl/serial_operand_host_if.sv
// Host-side serial operand link signals: request/operands in, serial pins, result/status out.
interface serial_operand_host_if;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       din;
  logic       dout;
  logic [7:0] result;
  logic       done;
  logic       busy;
  logic       timeout;

  modport master (
    output start, op_a, op_b, din,
    input  dout, result, done, busy, timeout
  );

  modport slave (
    input  start, op_a, op_b, din,
    output dout, result, done, busy, timeout
  );
endinterface

// File: rtl/serial_operand_host.sv
// Sends op_a then op_b as back-to-back 8N1 frames, then receives one 8N1 result frame.
// Define HOST_TIMEOUT_EN to bound the result wait to TIMEOUT_BITS idle bit periods.
module serial_operand_host #(
  parameter int BAUD_RATE     = 9600,
  parameter int SAMPLE_RATIO  = 16,
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int TIMEOUT_BITS  = 64
) (
  input logic            clk,
  input logic            reset,
  serial_operand_host_if.slave bus
);

  localparam int SAMPLE_CLKS = CLK_FREQUENCY / BAUD_RATE / SAMPLE_RATIO;
  localparam int DIV_W = (SAMPLE_CLKS > 1) ? $clog2(SAMPLE_CLKS) : 1;
  localparam int SMP_W = (SAMPLE_RATIO > 1) ? $clog2(SAMPLE_RATIO) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SAMPLE_CLKS - 1);
  localparam logic [SMP_W-1:0] SMP_MAX = SMP_W'(SAMPLE_RATIO - 1);
  localparam logic [SMP_W-1:0] SMP_MID = SMP_W'(SAMPLE_RATIO / 2 - 1);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_R, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [SMP_W-1:0] smp_cnt;
  logic [3:0]       bit_cnt;
  logic [8:0]       tx_sh;
  logic [7:0]       op_b_q;
  logic             dout_q;
  logic             sync1;
  logic             sync2;
  logic             sync3;
  logic             rx_act;
  logic [7:0]       rx_sh;
  logic [7:0]       result_q;
  logic             to_hit;
  logic             to_flag;

  logic div_end;
  logic smp_end;
  logic tx_bit_end;
  logic frame_end;
  logic rx_fall;
  logic rx_mid;
  logic rx_good;

  assign div_end    = (div_cnt == DIV_MAX);
  assign smp_end    = (smp_cnt == SMP_MAX);
  assign tx_bit_end = div_end && smp_end;
  assign frame_end  = tx_bit_end && (bit_cnt == 4'd9);
  assign rx_fall    = sync3 && !sync2;
  assign rx_mid     = rx_act && div_end && (smp_cnt == SMP_MID);
  assign rx_good    = rx_mid && (bit_cnt == 4'd9) && sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = SEND_A;
      SEND_A:  if (frame_end) state_nxt = SEND_B;
      SEND_B:  if (frame_end) state_nxt = WAIT_R;
      WAIT_R:  if (rx_good || to_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state != IDLE);
    bus.done    = (state == DONE);
    bus.timeout = (state == DONE) && to_flag;
    bus.dout    = dout_q;
    bus.result  = result_q;
  end

  // Transmit shifter holds {stop, data}; the start bit is driven directly on load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= 1'b1;
      tx_sh  <= '1;
      op_b_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          dout_q <= 1'b1;
          if (bus.start) begin
            tx_sh  <= {1'b1, bus.op_a};
            op_b_q <= bus.op_b;
            dout_q <= 1'b0;
          end
        end
        SEND_A, SEND_B: begin
          if (tx_bit_end) begin
            if (bit_cnt == 4'd9) begin
              dout_q <= (state == SEND_B);
              tx_sh  <= {1'b1, op_b_q};
            end else begin
              dout_q <= tx_sh[0];
              tx_sh  <= {1'b1, tx_sh[8:1]};
            end
          end
        end
        default: dout_q <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) {sync3, sync2, sync1} <= 3'b111;
    else       {sync3, sync2, sync1} <= {sync2, sync1, bus.din};
  end

  // Divider, sample and bit counters are shared: transmit owns them in SEND_*, receive in WAIT_R.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      smp_cnt <= '0;
      bit_cnt <= '0;
      rx_act  <= 1'b0;
      rx_sh   <= '0;
    end else begin
      unique case (state)
        SEND_A, SEND_B: begin
          if (div_end) begin
            div_cnt <= '0;
            if (smp_end) begin
              smp_cnt <= '0;
              bit_cnt <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
            end else begin
              smp_cnt <= smp_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        WAIT_R: begin
          if (!rx_act) begin
            div_cnt <= '0;
            smp_cnt <= '0;
            bit_cnt <= '0;
            rx_act  <= rx_fall;
          end else begin
            if (div_end) begin
              div_cnt <= '0;
              smp_cnt <= smp_end ? '0 : smp_cnt + 1'b1;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
            if (rx_mid) begin
              bit_cnt <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
              if (bit_cnt == 4'd0)      rx_act <= !sync2;
              else if (bit_cnt == 4'd9) rx_act <= 1'b0;
              else                      rx_sh  <= {sync2, rx_sh[7:1]};
            end
          end
        end
        default: begin
          div_cnt <= '0;
          smp_cnt <= '0;
          bit_cnt <= '0;
          rx_act  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            result_q <= '0;
    else if ((state == WAIT_R) && rx_good) result_q <= rx_sh;
  end

`ifdef HOST_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * SAMPLE_CLKS * SAMPLE_RATIO;
  localparam int TO_W     = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_LIMIT - 1);

  logic [TO_W-1:0] to_cnt;

  assign to_hit = (state == WAIT_R) && !rx_act && (to_cnt == TO_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           to_cnt <= '0;
    else if ((state != WAIT_R) || rx_act) to_cnt <= '0;
    else                                 to_cnt <= to_cnt + 1'b1;
  end

  // A valid byte landing in the same cycle as the timeout takes precedence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_flag <= 1'b0;
    else       to_flag <= to_hit && !rx_good;
  end
`else
  assign to_hit  = 1'b0;
  assign to_flag = 1'b0;
`endif

endmodule

// File: tb/tb_serial_operand_host.sv
// Randomized bench for serial_operand_host: frame-level reference model for the host and device sides.
module tb_serial_operand_host;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT      = 160;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_operand_host_if bus_if();

  serial_operand_host #(
    .BAUD_RATE    (BAUD),
    .SAMPLE_RATIO (16),
    .CLK_FREQUENCY(CLK_FREQ),
    .TIMEOUT_BITS (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic [7:0] done_res = 8'h00;
  logic       done_to  = 1'b0;
  logic       done_busy = 1'b0;
  logic [7:0] exp_result;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_if.done === 1'b1) begin
      done_cnt++;
      done_cyc  = cyc;
      done_res  = bus_if.result;
      done_to   = bus_if.timeout;
      done_busy = bus_if.busy;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish in cycle budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_checks(input logic [7:0] res_before);
    check("rst_dout", bus_if.dout, 1'b1);
    check("rst_result", bus_if.result, 8'h00);
    check("rst_busy", bus_if.busy, 1'b0);
    check("rst_done", bus_if.done, 1'b0);
    check("rst_timeout", bus_if.timeout, 1'b0);
    if (res_before != 8'h00) check("rst_result_cleared", (bus_if.result != res_before), 1'b1);
  endtask

  // Host side: expected line is {stop, data, start} for A then B, each bit BIT cycles long.
  task automatic send_host(input logic [7:0] a, input logic [7:0] b, input bit pulse_b);
    logic [9:0] fa;
    logic [9:0] fb;
    fa = {1'b1, a, 1'b0};
    fb = {1'b1, b, 1'b0};
    check("idle_busy", bus_if.busy, 1'b0);
    check("idle_dout", bus_if.dout, 1'b1);
    bus_if.op_a  = a;
    bus_if.op_b  = b;
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    bus_if.op_a  = 8'($urandom);
    bus_if.op_b  = 8'($urandom);
    check("busy_rise", bus_if.busy, 1'b1);
    for (int c = 0; c < 20 * BIT; c++) begin
      int   k;
      int   off;
      logic expb;
      k    = c / BIT;
      off  = c % BIT;
      expb = (k < 10) ? fa[k] : fb[k - 10];
      if (off == 0 || off == BIT / 2 || off == BIT - 1) check("tx_bit", bus_if.dout, expb);
      if (pulse_b && c == 15 * BIT) begin
        bus_if.start = 1'b1;
        bus_if.op_a  = 8'($urandom);
        bus_if.op_b  = 8'($urandom);
      end
      if (pulse_b && c == 15 * BIT + 1) bus_if.start = 1'b0;
      step();
    end
    check("wait_dout", bus_if.dout, 1'b1);
    check("wait_busy", bus_if.busy, 1'b1);
  endtask

  task automatic dev_frame(input logic [7:0] d, input logic stop, output int fall);
    logic [9:0] f;
    f    = {stop, d, 1'b0};
    fall = cyc;
    for (int k = 0; k < 10; k++) begin
      bus_if.din = f[k];
      repeat (BIT) step();
    end
    bus_if.din = 1'b1;
  endtask

  task automatic expect_done(input logic [7:0] exp_res, input int prev, input int fall);
    for (int i = 0; i < 400 && done_cnt == prev; i++) step();
    repeat (20) step();
    check("done_count", done_cnt - prev, 1);
    check("result", done_res, exp_res);
    check("done_timeout", done_to, 1'b0);
    check("done_busy", done_busy, 1'b1);
    check("done_latency_ok", (done_cyc - fall >= 1500) && (done_cyc - fall <= 1560), 1'b1);
    check("post_busy", bus_if.busy, 1'b0);
    check("post_done", bus_if.done, 1'b0);
    check("result_hold", bus_if.result, exp_res);
  endtask

  initial begin
    int         prev;
    int         fall;
    logic [7:0] d;
    reset        = 1'b1;
    bus_if.din   = 1'b1;
    bus_if.start = 1'b0;
    bus_if.op_a  = 8'h00;
    bus_if.op_b  = 8'h00;
    exp_result   = 8'h00;
    #3;
    reset_checks(8'h00);
    repeat (3) step();
    reset = 1'b0;
    repeat (5) step();

    // Known operands, second start ignored during SEND_B, reply 0xD7.
    send_host(8'h35, 8'hA2, 1'b1);
    prev = done_cnt;
    repeat (5) step();
    dev_frame(8'hD7, 1'b1, fall);
    exp_result = 8'hD7;
    expect_done(exp_result, prev, fall);
    repeat (50) step();
    check("no_restart_busy", bus_if.busy, 1'b0);

    // Framing error frame is dropped, next valid frame completes.
    send_host(8'($urandom), 8'($urandom), 1'b0);
    prev = done_cnt;
    repeat (3) step();
    dev_frame(8'h5A, 1'b0, fall);
    repeat (BIT) step();
    check("bad_frame_no_done", done_cnt - prev, 0);
    check("bad_frame_busy", bus_if.busy, 1'b1);
    check("bad_frame_result", bus_if.result, exp_result);
    dev_frame(8'h3C, 1'b1, fall);
    exp_result = 8'h3C;
    expect_done(exp_result, prev, fall);

`ifdef HOST_TIMEOUT_EN
    begin
      int w0;
      send_host(8'($urandom), 8'($urandom), 1'b0);
      w0   = cyc;
      prev = done_cnt;
      for (int i = 0; i < 1000 && done_cnt == prev; i++) step();
      check("to_count", done_cnt - prev, 1);
      check("to_latency", done_cyc - w0, 4 * BIT);
      check("to_flag", done_to, 1'b1);
      check("to_result", done_res, exp_result);
      step();
      check("to_clear", bus_if.timeout, 1'b0);
    end
`endif

    // Reset in the middle of frame A, then a clean transaction.
    bus_if.op_a  = 8'h00;
    bus_if.op_b  = 8'h00;
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    repeat (700) step();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    reset_checks(exp_result);
    step();
    reset = 1'b0;
    exp_result = 8'h00;
    for (int i = 0; i < 3; i++) begin
      repeat (100) step();
      check("abort_dout", bus_if.dout, 1'b1);
      check("abort_busy", bus_if.busy, 1'b0);
    end
    send_host(8'h01, 8'($urandom), 1'b0);
    prev = done_cnt;
    d    = 8'($urandom);
    repeat (4) step();
    dev_frame(d, 1'b1, fall);
    exp_result = d;
    expect_done(exp_result, prev, fall);

    for (int t = 0; t < 3; t++) begin
      send_host(8'($urandom), 8'($urandom), 1'b0);
      prev = done_cnt;
      d    = 8'($urandom);
      repeat ($urandom_range(2, 60)) step();
      dev_frame(d, 1'b1, fall);
      exp_result = d;
      expect_done(exp_result, prev, fall);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
